// File: rtl/rv_regfile.sv
// rv_regfile: parametrised general-purpose register file for the tinyrv core.
// It has two combinational read ports and one core write port, with optional
// hardwired-zero r0 and optional same-cycle write-to-read bypass. A
// byte-serial debug port lets a host load or dump a register MSB first while
// the core keeps running.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   src1/src2 -> srcN_dat  combinational read ports
//   tgt, tgt_dat, we       core write port
//   dbg_req/wr/addr        start a debug load (wr=1) or dump (wr=0)
//   dbg_bvalid/wbyte       load byte stream
//   dbg_rvalid/rbyte       dump byte stream (rbyte is 0 when not valid)
//   dbg_busy               debug transaction in progress
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for dbg_req
// S_LOAD   | assembling load bytes, MSB first
// S_COMMIT | writing assembled word; waits while core writes same reg
// S_DUMP   | streaming the snapshot out one byte per cycle
module rv_regfile #(
   parameter int WIDTH   = 16,
   parameter int NREGS   = 8,
   parameter int AW      = 3,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    src1,
   input  logic [AW-1:0]    src2,
   output logic [WIDTH-1:0] src1_dat,
   output logic [WIDTH-1:0] src2_dat,
   input  logic [AW-1:0]    tgt,
   input  logic [WIDTH-1:0] tgt_dat,
   input  logic             we,
   input  logic             dbg_req,
   input  logic             dbg_wr,
   input  logic [AW-1:0]    dbg_addr,
   input  logic             dbg_bvalid,
   input  logic [7:0]       dbg_wbyte,
   output logic             dbg_rvalid,
   output logic [7:0]       dbg_rbyte,
   output logic             dbg_busy
);

   localparam int BYTES = WIDTH / 8;
   localparam int CW    = $clog2(BYTES + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DUMP} state_t;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] asm_q, asm_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             busy_q, busy_d;
   logic             rvalid_q, rvalid_d;
   logic [7:0]       rbyte_q, rbyte_d;

   logic [WIDTH-1:0] src1_raw, src2_raw, dbg_raw;
   logic             core_wr_ok, dbg_wr_ok, commit_fire;

   // Address decode. Out-of-range addresses and (optionally) r0 never match,
   // so they read as 0 and writes to them are dropped.
   always_comb begin
      src1_raw   = '0;
      src2_raw   = '0;
      dbg_raw    = '0;
      core_wr_ok = 1'b0;
      dbg_wr_ok  = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (!((ZERO_R0 != 0) && (i == 0))) begin
            if (src1 == AW'(i))     src1_raw   = regs_q[i];
            if (src2 == AW'(i))     src2_raw   = regs_q[i];
            if (dbg_addr == AW'(i)) dbg_raw    = regs_q[i];
            if (tgt == AW'(i))      core_wr_ok = we;
            if (addr_q == AW'(i))   dbg_wr_ok  = 1'b1;
         end
      end
   end

   assign src1_dat = ((BYPASS != 0) && core_wr_ok && (src1 == tgt)) ? tgt_dat : src1_raw;
   assign src2_dat = ((BYPASS != 0) && core_wr_ok && (src2 == tgt)) ? tgt_dat : src2_raw;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      shift_d     = shift_q;
      busy_d      = busy_q;
      rvalid_d    = 1'b0;
      rbyte_d     = 8'h00;
      commit_fire = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dbg_req) begin
               addr_d = dbg_addr;
               cnt_d  = '0;
               busy_d = 1'b1;
               if (dbg_wr) begin
                  state_d = S_LOAD;
               end else begin
                  // First byte is registered at the accept edge so it is
                  // valid in the very next cycle; dbg_raw is the pre-edge value.
                  state_d  = S_DUMP;
                  rvalid_d = 1'b1;
                  rbyte_d  = dbg_raw[WIDTH-1 -: 8];
                  shift_d  = dbg_raw << 8;
                  cnt_d    = CW'(1);
               end
            end
         end
         S_LOAD: begin
            if (dbg_bvalid) begin
               asm_d = (asm_q << 8) | WIDTH'(dbg_wbyte);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(BYTES - 1)) state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // A colliding core write takes this edge; retry on the next one.
            if (!(we && (tgt == addr_q))) begin
               commit_fire = 1'b1;
               state_d     = S_IDLE;
               busy_d      = 1'b0;
            end
         end
         S_DUMP: begin
            if (cnt_q == CW'(BYTES)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               rvalid_d = 1'b1;
               rbyte_d  = shift_q[WIDTH-1 -: 8];
               shift_d  = shift_q << 8;
               cnt_d    = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Core and commit writes never hit the same register in one edge because
   // COMMIT stalls on a collision.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NREGS; i++) begin
         if (core_wr_ok && (tgt == AW'(i)))                 regs_d[i] = tgt_dat;
         if (commit_fire && dbg_wr_ok && (addr_q == AW'(i))) regs_d[i] = asm_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         state_q  <= S_IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         asm_q    <= '0;
         shift_q  <= '0;
         busy_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rbyte_q  <= 8'h00;
      end else begin
         regs_q   <= regs_d;
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         asm_q    <= asm_d;
         shift_q  <= shift_d;
         busy_q   <= busy_d;
         rvalid_q <= rvalid_d;
         rbyte_q  <= rbyte_d;
      end
   end

   assign dbg_busy   = busy_q;
   assign dbg_rvalid = rvalid_q;
   assign dbg_rbyte  = rbyte_q;

endmodule

// File: tb/tb_rv_regfile.sv
module tb_rv_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  src1, src2, tgt, dbg_addr;
   logic [15:0] src1_dat, src2_dat, tgt_dat;
   logic        we, dbg_req, dbg_wr, dbg_bvalid;
   logic [7:0]  dbg_wbyte, dbg_rbyte;
   logic        dbg_rvalid, dbg_busy;

   logic [3:0]  src1_w, src2_w, tgt_w, dbg_addr_w;
   logic [31:0] src1_dat_w, src2_dat_w, tgt_dat_w;
   logic        we_w, dbg_req_w, dbg_wr_w, dbg_bvalid_w;
   logic [7:0]  dbg_wbyte_w, dbg_rbyte_w;
   logic        dbg_rvalid_w, dbg_busy_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rv_regfile dut (
      .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2),
      .src1_dat(src1_dat), .src2_dat(src2_dat), .tgt(tgt), .tgt_dat(tgt_dat),
      .we(we), .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
      .dbg_bvalid(dbg_bvalid), .dbg_wbyte(dbg_wbyte), .dbg_rvalid(dbg_rvalid),
      .dbg_rbyte(dbg_rbyte), .dbg_busy(dbg_busy)
   );

   rv_regfile #(.WIDTH(32), .NREGS(16), .AW(4), .ZERO_R0(1), .BYPASS(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .src1(src1_w), .src2(src2_w),
      .src1_dat(src1_dat_w), .src2_dat(src2_dat_w), .tgt(tgt_w), .tgt_dat(tgt_dat_w),
      .we(we_w), .dbg_req(dbg_req_w), .dbg_wr(dbg_wr_w), .dbg_addr(dbg_addr_w),
      .dbg_bvalid(dbg_bvalid_w), .dbg_wbyte(dbg_wbyte_w), .dbg_rvalid(dbg_rvalid_w),
      .dbg_rbyte(dbg_rbyte_w), .dbg_busy(dbg_busy_w)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         src1 = 3'(a);
         src2 = 3'(7 - a);
         #1;
         total++;
         if (src1_dat !== 16'h0000) begin
            bad++; $display("FAIL reset_src1 a=%0d got=%h exp=0000", a, src1_dat);
         end
         total++;
         if (src2_dat !== 16'h0000) begin
            bad++; $display("FAIL reset_src2 a=%0d got=%h exp=0000", 7 - a, src2_dat);
         end
      end
      total++;
      if ({dbg_busy, dbg_rvalid, dbg_rbyte} !== 10'h000) begin
         bad++; $display("FAIL reset_dbg got busy=%b rvalid=%b rbyte=%h exp 0/0/00", dbg_busy, dbg_rvalid, dbg_rbyte);
      end
      total++;
      if ({dbg_busy_w, dbg_rvalid_w} !== 2'b00) begin
         bad++; $display("FAIL reset_dbg_w got busy=%b rvalid=%b exp 0/0", dbg_busy_w, dbg_rvalid_w);
      end
   endtask

   task automatic test_core_write();
      we = 1'b1; tgt = 3'd3; tgt_dat = 16'hBEEF; src1 = 3'd3;
      #1;
      total++;
      if (src1_dat !== 16'hBEEF) begin
         bad++; $display("FAIL bypass_r3 got=%h exp=beef", src1_dat);
      end
      tick();
      we = 1'b0; tgt_dat = 16'h0000;
      #1;
      total++;
      if (src1_dat !== 16'hBEEF) begin
         bad++; $display("FAIL stored_r3 got=%h exp=beef", src1_dat);
      end
      we = 1'b1; tgt = 3'd0; tgt_dat = 16'h1234; src2 = 3'd0;
      #1;
      total++;
      if (src2_dat !== 16'h0000) begin
         bad++; $display("FAIL r0_bypass got=%h exp=0000", src2_dat);
      end
      tick();
      we = 1'b0;
      #1;
      total++;
      if (src2_dat !== 16'h0000) begin
         bad++; $display("FAIL r0_stored got=%h exp=0000", src2_dat);
      end
   endtask

   task automatic test_load();
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 3'd5; src1 = 3'd5;
      tick();
      dbg_req = 1'b0; dbg_wr = 1'b0;
      #1;
      total++;
      if (dbg_busy !== 1'b1) begin
         bad++; $display("FAIL load_busy got=%b exp=1", dbg_busy);
      end
      dbg_bvalid = 1'b1; dbg_wbyte = 8'hCA;
      tick();
      dbg_bvalid = 1'b0; dbg_wbyte = 8'h55;
      tick();
      dbg_bvalid = 1'b1; dbg_wbyte = 8'hFE;
      tick();
      dbg_bvalid = 1'b0;
      #1;
      total++;
      if (src1_dat !== 16'h0000 || dbg_busy !== 1'b1) begin
         bad++; $display("FAIL load_precommit got dat=%h busy=%b exp 0000/1", src1_dat, dbg_busy);
      end
      tick();
      #1;
      total++;
      if (src1_dat !== 16'hCAFE) begin
         bad++; $display("FAIL load_r5 got=%h exp=cafe", src1_dat);
      end
      total++;
      if (dbg_busy !== 1'b0) begin
         bad++; $display("FAIL load_done_busy got=%b exp=0", dbg_busy);
      end
   endtask

   task automatic test_dump();
      src1 = 3'd3;
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 3'd3;
      we = 1'b1; tgt = 3'd3; tgt_dat = 16'h1111;
      tick();
      dbg_req = 1'b0; we = 1'b0;
      #1;
      total++;
      if (dbg_rvalid !== 1'b1 || dbg_rbyte !== 8'hBE) begin
         bad++; $display("FAIL dump_b0 got v=%b b=%h exp 1/be", dbg_rvalid, dbg_rbyte);
      end
      total++;
      if (src1_dat !== 16'h1111) begin
         bad++; $display("FAIL dump_core_r3 got=%h exp=1111", src1_dat);
      end
      tick();
      total++;
      if (dbg_rvalid !== 1'b1 || dbg_rbyte !== 8'hEF) begin
         bad++; $display("FAIL dump_b1 got v=%b b=%h exp 1/ef", dbg_rvalid, dbg_rbyte);
      end
      tick();
      total++;
      if (dbg_rvalid !== 1'b0 || dbg_rbyte !== 8'h00 || dbg_busy !== 1'b0) begin
         bad++; $display("FAIL dump_end got v=%b b=%h busy=%b exp 0/00/0", dbg_rvalid, dbg_rbyte, dbg_busy);
      end
   endtask

   task automatic test_commit_collision();
      src1 = 3'd2;
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 3'd2;
      tick();
      dbg_req = 1'b0;
      dbg_bvalid = 1'b1; dbg_wbyte = 8'h5A;
      tick();
      dbg_wbyte = 8'hA5;
      tick();
      dbg_bvalid = 1'b0;
      we = 1'b1; tgt = 3'd2; tgt_dat = 16'h0042;
      #1;
      total++;
      if (src1_dat !== 16'h0042) begin
         bad++; $display("FAIL coll_bypass got=%h exp=0042", src1_dat);
      end
      tick();
      we = 1'b0;
      #1;
      total++;
      if (dbg_busy !== 1'b1 || src1_dat !== 16'h0042) begin
         bad++; $display("FAIL coll_stall got busy=%b dat=%h exp 1/0042", dbg_busy, src1_dat);
      end
      tick();
      total++;
      if (dbg_busy !== 1'b0 || src1_dat !== 16'h5AA5) begin
         bad++; $display("FAIL coll_final got busy=%b dat=%h exp 0/5aa5", dbg_busy, src1_dat);
      end
   endtask

   task automatic test_reset_abort();
      src2 = 3'd4;
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 3'd4;
      tick();
      dbg_req = 1'b0;
      dbg_bvalid = 1'b1; dbg_wbyte = 8'h11;
      tick();
      dbg_bvalid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (dbg_busy !== 1'b0) begin
         bad++; $display("FAIL abort_busy got=%b exp=0", dbg_busy);
      end
      dbg_bvalid = 1'b1; dbg_wbyte = 8'h22;
      tick();
      dbg_bvalid = 1'b0;
      tick();
      tick();
      total++;
      if (src2_dat !== 16'h0000 || dbg_busy !== 1'b0) begin
         bad++; $display("FAIL abort_r4 got dat=%h busy=%b exp 0000/0", src2_dat, dbg_busy);
      end
   endtask

   task automatic test_wide_dump();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h89; exp_b[1] = 8'hAB; exp_b[2] = 8'hCD; exp_b[3] = 8'hEF;
      we_w = 1'b1; tgt_w = 4'd15; tgt_dat_w = 32'h89AB_CDEF;
      tick();
      we_w = 1'b0;
      src1_w = 4'd15;
      #1;
      total++;
      if (src1_dat_w !== 32'h89AB_CDEF) begin
         bad++; $display("FAIL wide_r15 got=%h exp=89abcdef", src1_dat_w);
      end
      dbg_req_w = 1'b1; dbg_wr_w = 1'b0; dbg_addr_w = 4'd15;
      tick();
      dbg_req_w = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         total++;
         if (dbg_rvalid_w !== 1'b1 || dbg_rbyte_w !== exp_b[b]) begin
            bad++; $display("FAIL wide_b%0d got v=%b b=%h exp 1/%h", b, dbg_rvalid_w, dbg_rbyte_w, exp_b[b]);
         end
         tick();
      end
      total++;
      if (dbg_rvalid_w !== 1'b0 || dbg_busy_w !== 1'b0) begin
         bad++; $display("FAIL wide_end got v=%b busy=%b exp 0/0", dbg_rvalid_w, dbg_busy_w);
      end
   endtask

   initial begin
      rst_n = 1'b0; src1 = '0; src2 = '0; tgt = '0; tgt_dat = '0; we = 1'b0;
      dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_bvalid = 1'b0; dbg_wbyte = '0;
      src1_w = '0; src2_w = '0; tgt_w = '0; tgt_dat_w = '0; we_w = 1'b0;
      dbg_req_w = 1'b0; dbg_wr_w = 1'b0; dbg_addr_w = '0; dbg_bvalid_w = 1'b0; dbg_wbyte_w = '0;
      test_reset();
      test_core_write();
      test_load();
      test_dump();
      test_commit_collision();
      test_reset_abort();
      test_wide_dump();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv_regfile.md
# rv_regfile

Parametrised general-purpose register file for the tinyrv core. Generalises the fixed 8×16 file with configurable width, depth, hardwired-zero r0 and optional write-to-read bypass. Adds a byte-serial debug port so a host can load and dump any register over the 8-bit TinyTapeout pins while the core keeps running. Sits between instruction decode (source/target selectors) and the ALU/memory datapath.

## Interface
- WIDTH, 16: register width in bits; multiple of 8.
- NREGS, 8: number of registers.
- AW, 3: address width; NREGS ≤ 2**AW.
- ZERO_R0, 1: 1 = register 0 reads 0, writes to it ignored.
- BYPASS, 1: 1 = same-cycle core write forwarded to read ports.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- src1, src2  in  AW  read addresses.
- src1_dat, src2_dat  out  WIDTH  read data, combinational.
- tgt  in  AW  core write address.
- tgt_dat  in  WIDTH  core write data.
- we  in  1  core write enable.
- dbg_req  in  1  start debug transaction (sampled in IDLE only).
- dbg_wr  in  1  with dbg_req: 1 = load, 0 = dump.
- dbg_addr  in  AW  debug register address, sampled with dbg_req.
- dbg_bvalid  in  1  load byte valid.
- dbg_wbyte  in  8  load byte.
- dbg_rvalid  out  1  dump byte valid.
- dbg_rbyte  out  8  dump byte.
- dbg_busy  out  1  transaction in progress.

## Operation
- BYTES = WIDTH/8. Byte order MSB first on both directions.
- Addresses ≥ NREGS: writes dropped, reads return 0 (core and debug).
- Core read: srcN_dat = regs[srcN]; 0 if ZERO_R0 and srcN==0. If BYPASS and we and tgt==srcN and write not suppressed, srcN_dat = tgt_dat.
- Core write: regs[tgt] <= tgt_dat at edge when we; suppressed for tgt==0 when ZERO_R0.
- FSM states: IDLE, LOAD, COMMIT, DUMP.
- IDLE: dbg_req=1 → capture dbg_addr, byte counter=0. dbg_wr=1 → LOAD. dbg_wr=0 → snapshot regs[dbg_addr] (pre-edge value, ignoring same-edge core write) into shift register → DUMP.
- LOAD: each cycle with dbg_bvalid=1 shifts dbg_wbyte into assembly register, counter+1; gaps allowed. Byte BYTES-1 accepted → COMMIT.
- COMMIT: if we && tgt==captured addr, core write wins; stay in COMMIT, retry next cycle. Otherwise write assembled word (ZERO_R0/range rules apply) → IDLE.
- DUMP: dbg_rvalid=1, dbg_rbyte = shift register top byte, one byte per cycle, no backpressure; after BYTES bytes → IDLE.
- dbg_req outside IDLE ignored; dbg_bvalid outside LOAD ignored.
- Core and debug ports to different registers proceed independently in the same cycle.

## Timing
- Reset: all registers 0, FSM IDLE, counter 0, dbg_busy=0, dbg_rvalid=0, dbg_rbyte=0. Reset mid-transaction aborts it; no partial write reaches the file.
- Core write latency: visible on read ports the cycle after the edge (same cycle via bypass when BYPASS=1).
- dbg_busy=1 in LOAD, COMMIT, DUMP (from cycle after accepting dbg_req until FSM returns to IDLE).
- Dump: accept at edge T; bytes valid in cycles T+1 … T+BYTES.
- Load: minimum latency with back-to-back bytes: accept at T, bytes at T+1 … T+BYTES, commit edge at T+BYTES+1; visible from T+BYTES+2 (later per COMMIT stall).
- dbg_rbyte holds 0 when dbg_rvalid=0.

## Test plan
- Reset then read all src addresses → 0; dbg_busy=0, dbg_rvalid=0.
- we=1, tgt=3, tgt_dat=0xBEEF, src1=3 same cycle → src1_dat=0xBEEF (BYPASS=1); next cycle still 0xBEEF; tgt=0, tgt_dat=0x1234 → src2=0 reads 0.
- Debug load r5: req/wr=1, bytes 0xCA, gap cycle, 0xFE → after commit src1=5 reads 0xCAFE; dbg_busy low after commit.
- Debug dump r3 (0xBEEF) while core writes r3=0x1111 at accept edge → rbyte 0xBE, 0xEF on T+1, T+2; src1=3 then reads 0x1111.
- Load r2 with commit colliding with core we to r2 (0x0042) → COMMIT stalls one cycle, final r2 = debug value; dbg_busy extended by one cycle.
- rst_n low after one load byte → FSM IDLE, target register unchanged; WIDTH=32/NREGS=16 build: 4-byte dump of r15 correct MSB first.
